// File: rtl/iiitb_sdm_pkg.sv
// Shared defaults and mode encoding for the
// parametrised serial sequence detector.
package iiitb_sdm_pkg;
  localparam int         PAT_W_DEF   = 4;
  localparam int         CNT_W_DEF   = 8;
  localparam logic [3:0] PAT_RST_DEF = 4'b1010;
  localparam logic       OVL         = 1'b1;
  localparam logic       NOVL        = 1'b0;
endpackage

// File: rtl/iiitb_sat_cnt.sv
// Saturating match counter with synchronous clear
// and a sticky saturation flag.
module iiitb_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         sat
);
  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_inc;

  always_comb begin
    cnt_inc = cnt + W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && cnt != MAX) begin
      cnt <= cnt_inc;
      if (cnt_inc == MAX) sat <= 1'b1;
    end
  end
endmodule

// File: rtl/iiitb_sdm_param.sv
// Runtime-loadable serial pattern detector with
// overlap control, enable qualification and match count.
module iiitb_sdm_param
  import iiitb_sdm_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_RST_DEF,
  parameter int               CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FMAX = FW'(PAT_W);
  localparam logic [FW-1:0] FTHR = FW'(PAT_W - 1);

  logic [PAT_W-1:0] pattern;
  logic [PAT_W-1:0] hist;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_nx;
  logic [PAT_W-1:0] cand;
  logic             sample;
  logic             match;

  always_comb begin
    cand    = {hist[PAT_W-2:0], din};
    sample  = en && !pat_load;
    match   = sample && (fill >= FTHR) && (cand == pattern);
    fill_nx = fill;
    if (pat_load) begin
      fill_nx = '0;
    end else if (match && overlap == NOVL) begin
      fill_nx = '0;
    end else if (sample && fill != FMAX) begin
      fill_nx = fill + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern <= PAT_RST;
      hist    <= '0;
      fill    <= '0;
      y       <= 1'b0;
    end else begin
      y    <= match;
      fill <= fill_nx;
      if (pat_load) begin
        pattern <= pat_in;
        hist    <= '0;
      end else if (en) begin
        hist <= cand;
      end
    end
  end

  iiitb_sat_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .clr  (cnt_clr),
    .cnt  (match_cnt),
    .sat  (cnt_sat)
  );
endmodule

// File: tb/tb_iiitb_sdm_param.sv
// Randomised and directed bench for iiitb_sdm_param,
// two counter widths driven in parallel.
module tb_iiitb_sdm_param;
  logic       clk;
  logic       reset;
  logic       en;
  logic       din;
  logic       overlap;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       cnt_clr;
  logic       y8, y2, s8, s2;
  logic [7:0] c8;
  logic [1:0] c2;

  int checks = 0;
  int errors = 0;

  bit         q[$];
  logic [3:0] m_pat;
  logic       m_y, m_s8, m_s2;
  logic [7:0] m_c8;
  logic [1:0] m_c2;

  iiitb_sdm_param #(.CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .din(din),
    .overlap(overlap), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr),
    .y(y8), .match_cnt(c8), .cnt_sat(s8)
  );

  iiitb_sdm_param #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .din(din),
    .overlap(overlap), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr),
    .y(y2), .match_cnt(c2), .cnt_sat(s2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [13:0] act();
    return {y8, y2, c8, s8, c2, s2};
  endfunction

  function automatic logic [13:0] expv();
    return {m_y, m_y, m_c8, m_s8, m_c2, m_s2};
  endfunction

  task automatic model_reset();
    q.delete();
    m_pat = 4'b1010;
    m_y = 0; m_c8 = 0; m_s8 = 0; m_c2 = 0; m_s2 = 0;
  endtask

  // Drive one edge and advance the reference model
  task automatic cyc(input logic e, input logic d, input logic o,
                     input logic pl, input logic [3:0] pi,
                     input logic cc);
    logic [3:0] v;
    logic       hit;
    en = e; din = d; overlap = o;
    pat_load = pl; pat_in = pi; cnt_clr = cc;
    hit = 0;
    if (pl) begin
      m_pat = pi;
      q.delete();
    end else if (e) begin
      q.push_back(d);
      if (q.size() > 4) void'(q.pop_front());
      v = 0;
      foreach (q[i]) v = {v[2:0], q[i]};
      hit = (q.size() == 4) && (v == m_pat);
      if (hit && !o) q.delete();
    end
    m_y = hit;
    if (cc) begin
      m_c8 = 0; m_s8 = 0; m_c2 = 0; m_s2 = 0;
    end else if (hit) begin
      if (m_c8 != 8'hff) m_c8 = m_c8 + 1;
      if (m_c8 == 8'hff) m_s8 = 1;
      if (m_c2 != 2'h3) m_c2 = m_c2 + 1;
      if (m_c2 == 2'h3) m_s2 = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    en = 0; din = 0; overlap = 0;
    pat_load = 0; pat_in = 0; cnt_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask

  task automatic test_reset();
    logic [2:0] s;
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act() !== 14'h0) begin
      errors++;
      $display("FAIL reset got %h want 0", act());
    end
    reset = 1;
    s = 3'b101;
    for (int i = 2; i >= 0; i--) begin
      cyc(1, s[i], 1, 0, 0, 0);
      checks++;
      if (act() !== expv() || y8 !== 1'b0) begin
        errors++;
        $display("FAIL reset_fill[%0d] got %h want %h", i, act(), expv());
      end
    end
  endtask

  task automatic run_stream(input logic o, input string nm,
                            input logic [7:0] want_cnt);
    logic [10:0] s;
    s = 11'b01010100100;
    do_reset();
    for (int i = 10; i >= 0; i--) begin
      cyc(1, s[i], o, 0, 0, 0);
      checks++;
      if (act() !== expv()) begin
        errors++;
        $display("FAIL %s[%0d] got %h want %h", nm, 10 - i, act(), expv());
      end
    end
    checks++;
    if (c8 !== want_cnt) begin
      errors++;
      $display("FAIL %s_cnt got %0d want %0d", nm, c8, want_cnt);
    end
  endtask

  task automatic test_overlap();
    run_stream(1, "overlap", 8'd2);
  endtask

  task automatic test_nonoverlap();
    run_stream(0, "nonoverlap", 8'd1);
  endtask

  task automatic test_en_gaps();
    logic [6:0] e, d;
    e = 7'b1100011;
    d = 7'b1010110;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      cyc(e[i], d[i], 1, 0, 0, 0);
      checks++;
      if (act() !== expv() || y8 !== (i == 0)) begin
        errors++;
        $display("FAIL en_gap[%0d] got %h want %h", 6 - i, act(), expv());
      end
    end
  endtask

  task automatic test_pat_load();
    logic [7:0] s;
    do_reset();
    cyc(1, 1, 1, 1, 4'b0011, 0);
    s = 8'b00111010;
    for (int i = 7; i >= 0; i--) begin
      cyc(1, s[i], 1, 0, 0, 0);
      checks++;
      if (act() !== expv() || y8 !== (i == 4)) begin
        errors++;
        $display("FAIL pat_load[%0d] got %h want %h", 7 - i, act(), expv());
      end
    end
    // partial 0,0 then reload: trailing 1,1 must not match
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 4'b0011, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 1, 0, 0, 0);
      checks++;
      if (act() !== expv() || y8 !== 1'b0) begin
        errors++;
        $display("FAIL pat_mid[%0d] got %h want %h", i, act(), expv());
      end
    end
  endtask

  task automatic test_saturation();
    logic [9:0] s;
    s = 10'b1010101010;
    do_reset();
    for (int i = 9; i >= 0; i--) begin
      cyc(1, s[i], 1, 0, 0, 0);
      checks++;
      if (act() !== expv() || y2 !== (i <= 6 && i[0] == 0)) begin
        errors++;
        $display("FAIL sat[%0d] got %h want %h", 9 - i, act(), expv());
      end
    end
    checks++;
    if ({c2, s2, c8} !== {2'd3, 1'b1, 8'd4}) begin
      errors++;
      $display("FAIL sat_final got c2=%0d s2=%b c8=%0d want 3 1 4",
               c2, s2, c8);
    end
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 1);
    checks++;
    if ({y2, c2, s2, y8, c8, s8} !== {1'b1, 2'd0, 1'b0, 1'b1, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL clr_match got y=%b c2=%0d s2=%b c8=%0d want 1 0 0 0",
               y2, c2, s2, c8);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    #2;
    reset = 0;
    model_reset();
    #1;
    checks++;
    if (act() !== 14'h0) begin
      errors++;
      $display("FAIL async_rst got %h want 0", act());
    end
    @(posedge clk);
    #1;
    reset = 1;
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    checks++;
    if (act() !== expv() || y8 !== 1'b0) begin
      errors++;
      $display("FAIL async_discard got %h want %h", act(), expv());
    end
  endtask

  task automatic test_random();
    logic o;
    do_reset();
    o = 1;
    for (int i = 0; i < 600; i++) begin
      if (i % 16 == 0) o = 1'($urandom_range(0, 1));
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), o,
          1'($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 29) == 0));
      checks++;
      if (act() !== expv()) begin
        errors++;
        $display("FAIL random[%0d] got %h want %h", i, act(), expv());
      end
    end
  endtask

  initial begin
    reset = 0;
    en = 0; din = 0; overlap = 0;
    pat_load = 0; pat_in = 0; cnt_clr = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_en_gaps();
    test_pat_load();
    test_saturation();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
